// File: rtl/z80_io_port_bank.sv
// Z180 I/O port bank: NUM_IN synchronised input ports, NUM_OUT latched output
// ports with readback, per-port strobes and a sticky boot-ROM disable latch.
// All flops run on the falling edge of phi.
// Ports:
//   phi, reset_n          clock (falling edge), async active-low reset
//   iorq_n, rd_n, wr_n    CPU bus strobes (active low)
//   a, din                CPU address and write data
//   dout, dout_en         read data and bus-claim for the top-level mux (comb)
//   gpio_in, gpio_out     asynchronous input pins / output latches, 8 bits per port
//   wr_strobe, rd_strobe  one-phi pulse after a port write / input sample
//   rom_sel               1 = boot ROM mapped, cleared by a read of ROMSEL_PORT
module z80_io_port_bank #(
  parameter int unsigned NUM_IN      = 2,
  parameter int unsigned NUM_OUT     = 2,
  parameter logic [7:0]  BASE_ADDR   = 8'hf0,
  parameter logic [7:0]  OUT_RESET   = 8'h04,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ROMSEL_PORT = 8'hfe
) (
  input  logic                   phi,
  input  logic                   reset_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic [7:0]             a,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   dout_en,
  input  logic [8*NUM_IN-1:0]    gpio_in,
  output logic [8*NUM_OUT-1:0]   gpio_out,
  output logic [NUM_OUT-1:0]     wr_strobe,
  output logic [NUM_IN-1:0]      rd_strobe,
  output logic                   rom_sel
);

  localparam int unsigned MAX_PORTS = (NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT;
  localparam int unsigned BANK_LO   = 32'(BASE_ADDR);
  localparam int unsigned BANK_HI   = BANK_LO + 2 * MAX_PORTS - 1;
  localparam int unsigned ROMSEL_A  = 32'(ROMSEL_PORT);

  // Parameter sanity checks at elaboration
  if (NUM_IN < 1 || NUM_IN > 8) begin : g_bad_num_in
    $error("z80_io_port_bank: NUM_IN must be 1..8");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("z80_io_port_bank: NUM_OUT must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("z80_io_port_bank: SYNC_STAGES must be >= 2");
  end
  if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
    $error("z80_io_port_bank: BASE_ADDR must be even");
  end
  if (BANK_HI > 255) begin : g_bad_wrap
    $error("z80_io_port_bank: port bank wraps past 8'hff");
  end
  if (ROMSEL_A >= BANK_LO && ROMSEL_A <= BANK_HI) begin : g_bad_romsel
    $error("z80_io_port_bank: ROMSEL_PORT lies inside the port bank");
  end

  logic iorq, rd, wr;
  assign iorq = ~iorq_n;
  assign rd   = ~rd_n;
  assign wr   = ~wr_n;

  // Address decode
  logic [NUM_IN-1:0]  hit_in;
  logic [NUM_OUT-1:0] hit_out;
  logic               hit_romsel;

  for (genvar i = 0; i < int'(NUM_IN); i++) begin : g_dec_in
    assign hit_in[i] = (a == 8'(BANK_LO + 2 * i));
  end
  for (genvar i = 0; i < int'(NUM_OUT); i++) begin : g_dec_out
    assign hit_out[i] = (a == 8'(BANK_LO + 2 * i + 1));
  end
  assign hit_romsel = (a == ROMSEL_PORT);

  // Bus-cycle edge counter; saturates so each cycle yields exactly one tick
  logic [1:0] cnt;
  logic       bus_act, rd_tick, wr_tick;

  assign bus_act = iorq & (rd | wr);
  assign rd_tick = iorq & rd & (cnt == 2'd0);
  assign wr_tick = iorq & wr & (cnt == 2'd1);

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd3;
    end else if (!bus_act) begin
      cnt <= 2'd0;
    end else if (cnt != 2'd3) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Input synchroniser chain
  logic [8*NUM_IN-1:0] sync_q [SYNC_STAGES];

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Port registers, strobes and ROM-select latch
  logic [8*NUM_IN-1:0] sample_q;

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out  <= {NUM_OUT{OUT_RESET}};
      sample_q  <= '0;
      wr_strobe <= '0;
      rd_strobe <= '0;
      rom_sel   <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (wr_tick && hit_out[i]) gpio_out[8*i +: 8] <= din;
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (rd_tick && hit_in[i]) sample_q[8*i +: 8] <= sync_q[SYNC_STAGES-1][8*i +: 8];
      end
      wr_strobe <= {NUM_OUT{wr_tick}} & hit_out;
      rd_strobe <= {NUM_IN{rd_tick}} & hit_in;
      if (rd_tick && hit_romsel) rom_sel <= 1'b0;
    end
  end

  // Read mux: asynchronous on the decode, like the bus pins it replaces
  always_comb begin
    dout    = '0;
    dout_en = 1'b0;
    if (iorq && rd && ((|hit_in) || (|hit_out))) begin
      dout_en = 1'b1;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (hit_in[i]) dout = sample_q[8*i +: 8];
      end
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (hit_out[i]) dout = gpio_out[8*i +: 8];
      end
    end
  end

  // /RD and /WR are mutually exclusive on the bus
  a_rd_wr_excl : assert property (@(negedge phi) disable iff (!reset_n) !(!rd_n && !wr_n));

endmodule

// File: tb/tb_z80_io_port_bank.sv
// Scoreboard bench for z80_io_port_bank with default parameters.
module tb_z80_io_port_bank;

  logic        phi;
  logic        reset_n;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  a, din, dout;
  logic        dout_en;
  logic [15:0] gpio_in, gpio_out;
  logic [1:0]  wr_strobe, rd_strobe;
  logic        rom_sel;

  z80_io_port_bank dut (
    .phi       (phi),
    .reset_n   (reset_n),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a         (a),
    .din       (din),
    .dout      (dout),
    .dout_en   (dout_en),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .rom_sel   (rom_sel)
  );

  initial phi = 1'b0;
  always #5 phi = ~phi;

  typedef struct {
    string       name;
    logic [1:0]  ws;
    logic [1:0]  rs;
    logic        den;
    logic [7:0]  dat;
    logic [15:0] gpo;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_gpo  = 16'h0404;
  logic        den_q  = 1'b0;
  exp_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input string nm, input logic [1:0] ws, input logic [1:0] rs,
                      input logic den, input logic [7:0] dat);
    exp_t x;
    x.name = nm; x.ws = ws; x.rs = rs; x.den = den; x.dat = dat; x.gpo = m_gpo;
    exp_q.push_back(x);
  endtask

  task automatic bus_start(input logic [7:0] addr, input logic is_wr, input logic [7:0] data);
    @(posedge phi); #1;
    a = addr; din = data; iorq_n = 1'b0;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
  endtask

  task automatic bus_end();
    @(posedge phi); #1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge phi);
  endtask

  task automatic io_cycle(input logic [7:0] addr, input logic is_wr, input logic [7:0] data,
                          input int n);
    bus_start(addr, is_wr, data);
    edges(n);
    bus_end();
  endtask

  // Monitor: any strobe or a new bus claim is one DUT response to score
  initial begin
    forever begin
      @(posedge phi);
      if (reset_n && ((|wr_strobe) || (|rd_strobe) || (dout_en && !den_q))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event ws=%b rs=%b den=%b dout=%h required=no event",
                   wr_strobe, rd_strobe, dout_en, dout);
        end else begin
          e = exp_q.pop_front();
          if (wr_strobe !== e.ws || rd_strobe !== e.rs || dout_en !== e.den ||
              dout !== e.dat || gpio_out !== e.gpo) begin
            errors++;
            $display("FAIL %s actual ws=%b rs=%b den=%b dout=%h gpo=%h required ws=%b rs=%b den=%b dout=%h gpo=%h",
                     e.name, wr_strobe, rd_strobe, dout_en, dout, gpio_out,
                     e.ws, e.rs, e.den, e.dat, e.gpo);
          end
        end
      end
      den_q = dout_en;
    end
  end

  initial begin
    reset_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 8'h00; din = 8'h00; gpio_in = 16'hc03c;
    #23;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0404);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_rd_strobe", 32'(rd_strobe), 32'h0);
    chk("rst_rom_sel", 32'(rom_sel), 32'h1);
    chk("rst_dout_en", 32'(dout_en), 32'h0);
    @(posedge phi); #1 reset_n = 1'b1;

    // Plain write to output port 0
    m_gpo[7:0] = 8'h5a;
    push("wr_f1", 2'b01, 2'b00, 1'b0, 8'h00);
    io_cycle(8'hf1, 1'b1, 8'h5a, 3);
    chk("wr_f1_latch", 32'(gpio_out), 32'h045a);

    // Input port 1 read
    push("rd_f2", 2'b00, 2'b10, 1'b1, 8'hc0);
    io_cycle(8'hf2, 1'b0, 8'h00, 3);
    #1 chk("rd_f2_release_en", 32'(dout_en), 32'h0);

    // Output port readback
    push("rd_f1_readback", 2'b00, 2'b00, 1'b1, 8'h5a);
    io_cycle(8'hf1, 1'b0, 8'h00, 3);

    // Out-of-range read
    bus_start(8'hf8, 1'b0, 8'h00);
    edges(1);
    #1 chk("rd_f8_dout_en", 32'(dout_en), 32'h0);
    chk("rd_f8_dout", 32'(dout), 32'h0);
    edges(2);
    bus_end();

    // Write to an input-port address is ignored
    io_cycle(8'hf0, 1'b1, 8'h11, 3);
    #1 chk("wr_f0_ignored", 32'(gpio_out), 32'h045a);

    // Read with wait states; input changes after the sampling edge
    push("rd_f0_wait", 2'b00, 2'b01, 1'b1, 8'h3c);
    bus_start(8'hf0, 1'b0, 8'h00);
    edges(2);
    #1 gpio_in[7:0] = 8'ha5;
    edges(3);
    #1 chk("rd_f0_wait_dout_held", 32'(dout), 32'h3c);
    bus_end();

    // ROM-select port read
    bus_start(8'hfe, 1'b0, 8'h00);
    edges(1);
    #1 chk("rd_fe_dout_en", 32'(dout_en), 32'h0);
    edges(2);
    bus_end();
    #1 chk("rd_fe_rom_sel", 32'(rom_sel), 32'h0);

    // Write FE then read F0: latch stays cleared
    io_cycle(8'hfe, 1'b1, 8'h33, 3);
    push("rd_f0_after_fe", 2'b00, 2'b01, 1'b1, 8'ha5);
    io_cycle(8'hf0, 1'b0, 8'h00, 3);
    #1 chk("rom_sel_sticky", 32'(rom_sel), 32'h0);

    // Reset during a write to F3, released while the cycle is still in flight
    bus_start(8'hf3, 1'b1, 8'h77);
    edges(1);
    #2 reset_n = 1'b0;
    m_gpo = 16'h0404;
    #1 chk("midrst_gpio_out", 32'(gpio_out), 32'h0404);
    chk("midrst_rom_sel", 32'(rom_sel), 32'h1);
    @(posedge phi); #1 reset_n = 1'b1;
    edges(3);
    #1 chk("midrst_no_write", 32'(gpio_out), 32'h0404);
    chk("midrst_no_strobe", 32'(wr_strobe), 32'h0);
    bus_end();

    // Next full cycle writes normally
    m_gpo[15:8] = 8'h99;
    push("wr_f3_after_rst", 2'b10, 2'b00, 1'b0, 8'h00);
    io_cycle(8'hf3, 1'b1, 8'h99, 3);
    #1 chk("wr_f3_latch", 32'(gpio_out), 32'h9904);

    edges(4);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
